qdiv_seq: RTL

Sequential Q1.15 sign-magnitude fractional divider. It is the inverse operation to the datapath's combinational Q15 multiplier and uses the same sign-magnitude number format: bit N-1 is the sign, bits N-2:0 are the magnitude. The block sits beside the ALU as a multi-cycle coprocessor, used for AGC gain normalisation and correlation scaling in the receiver. It takes operands through a start/busy/done handshake and produces one quotient bit per cycle by restoring division.

---
 rtl/qdiv_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/qdiv_seq.sv
// Sequential Q1.15 sign-magnitude fractional divider (restoring, one quotient bit per cycle).
// Optional macro QDIV_ROUND_EN adds a guard iteration and round-half-up of the magnitude.
module qdiv_seq #(
    parameter int N = 16,
    parameter int Q = N - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic         ovf,
    output logic         div_by_zero
);

`ifdef QDIV_ROUND_EN
    localparam int ITER = Q + 1;
`else
    localparam int ITER = Q;
`endif
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_rem;
    logic [Q-1:0]    r_div;
    logic [ITER-2:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_quot;
    logic            r_ovf;
    logic            r_dbz;

    logic [Q-1:0]    w_a;
    logic [Q-1:0]    w_b;
    logic [N-1:0]    w_rem2;
    logic [N-1:0]    w_divExt;
    logic            w_ge;
    logic [N-1:0]    w_remNext;
    logic [ITER-1:0] w_accNext;
    logic [Q-1:0]    w_mag;

    assign w_a       = dividend[Q-1:0];
    assign w_b       = divisor[Q-1:0];
    assign w_rem2    = r_rem << 1;
    assign w_divExt  = {{(N-Q){1'b0}}, r_div};
    assign w_ge      = (w_rem2 >= w_divExt);
    assign w_remNext = w_ge ? (w_rem2 - w_divExt) : w_rem2;
    assign w_accNext = {r_acc, w_ge};

`ifdef QDIV_ROUND_EN
    // Guard bit is the last quotient bit; adding it to the truncated value rounds half up.
    logic [Q:0] w_sum;
    assign w_sum = {1'b0, w_accNext[ITER-1:1]} + {{Q{1'b0}}, w_accNext[0]};
    assign w_mag = w_sum[Q] ? {Q{1'b1}} : w_sum[Q-1:0];
`else
    assign w_mag = w_accNext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_div   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        r_sign <= dividend[N-1] ^ divisor[N-1];
                        r_div  <= w_b;
                        if (w_b == '0) begin
                            // Zero divisor keeps the dividend's own sign; 0/0 yields plain zero.
                            r_dbz   <= 1'b1;
                            r_ovf   <= 1'b0;
                            r_quot  <= (w_a == '0) ? '0 : {dividend[N-1], {Q{1'b1}}};
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_a >= w_b) begin
                            r_dbz   <= 1'b0;
                            r_ovf   <= 1'b1;
                            r_quot  <= {dividend[N-1] ^ divisor[N-1], {Q{1'b1}}};
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= {{(N-Q){1'b0}}, w_a};
                            r_acc   <= '0;
                            r_cnt   <= CW'(ITER - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_remNext;
                    r_acc <= w_accNext[ITER-2:0];
                    if (r_cnt == '0) begin
                        r_quot  <= {(w_mag != '0) ? r_sign : 1'b0, w_mag};
                        r_ovf   <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign ovf         = r_ovf;
    assign div_by_zero = r_dbz;

endmodule
